// File: rtl/match_event_counter_pkg.sv
// Shared constants for the match event counter: active-low segment
// patterns in {g,f,e,d,c,b,a} order and BCD digit limits.
package match_event_counter_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [3:0] BCD_NINE  = 4'd9;

    typedef struct packed {
        logic [3:0] tens;
        logic [3:0] units;
    } bcd2_t;

endpackage

// File: rtl/match_event_counter_bcd_to_7seg.sv
// Combinational BCD digit to active-low 7-segment decoder.
// Codes 10..15 cannot occur in normal operation and show blank.
module match_event_counter_bcd_to_7seg
    import match_event_counter_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        case (i_bcd)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/match_event_counter.sv
// Counts rising edges of the detector level z as 2-digit BCD, tracks the
// longest z-high run, and drives two active-low 7-segment digits.
module match_event_counter
    import match_event_counter_pkg::*;
#(
    parameter int RUN_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             z,
    input  logic             clr,
    input  logic             hold,
    output logic             evt,
    output logic [7:0]       count_bcd,
    output logic             ovf,
    output logic [RUN_W-1:0] run_max,
    output logic [6:0]       hex0,
    output logic [6:0]       hex1
);

    localparam logic [RUN_W-1:0] RUN_SAT = '1;

    logic             r_z_q;
    logic             r_evt;
    bcd2_t            r_count;
    logic             r_ovf;
    logic [RUN_W-1:0] r_run_cur;
    logic [RUN_W-1:0] r_run_max;
    logic [6:0]       r_hex0;
    logic [6:0]       r_hex1;

    logic             w_event;
    bcd2_t            w_count_next;
    logic             w_ovf_next;
    logic [RUN_W-1:0] w_run_next;
    logic [RUN_W-1:0] w_max_next;
    logic [6:0]       w_seg0;
    logic [6:0]       w_seg1;

    assign w_event = z & ~r_z_q;

    always_comb begin
        w_count_next = r_count;
        w_ovf_next   = r_ovf;
        if (clr) begin
            w_count_next = '0;
            w_ovf_next   = 1'b0;
        end else if (w_event) begin
            if (r_count.units == BCD_NINE) begin
                w_count_next.units = 4'd0;
                if (r_count.tens == BCD_NINE) begin
                    w_count_next.tens = 4'd0;
                    w_ovf_next        = 1'b1;
                end else begin
                    w_count_next.tens = r_count.tens + 4'd1;
                end
            end else begin
                w_count_next.units = r_count.units + 4'd1;
            end
        end
    end

    // run_max compares against the next run length so both move together
    always_comb begin
        w_run_next = '0;
        if (!clr && z) begin
            w_run_next = (r_run_cur == RUN_SAT) ? RUN_SAT
                                                : r_run_cur + 1'b1;
        end
        w_max_next = '0;
        if (!clr) begin
            w_max_next = (w_run_next > r_run_max) ? w_run_next : r_run_max;
        end
    end

    match_event_counter_bcd_to_7seg u_seg0 (
        .i_bcd (w_count_next.units),
        .o_seg (w_seg0)
    );

    match_event_counter_bcd_to_7seg u_seg1 (
        .i_bcd (w_count_next.tens),
        .o_seg (w_seg1)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_z_q     <= 1'b0;
            r_evt     <= 1'b0;
            r_count   <= '0;
            r_ovf     <= 1'b0;
            r_run_cur <= '0;
            r_run_max <= '0;
            r_hex0    <= SEG_0;
            r_hex1    <= SEG_0;
        end else begin
            r_z_q     <= z;
            r_evt     <= w_event & ~clr;
            r_count   <= w_count_next;
            r_ovf     <= w_ovf_next;
            r_run_cur <= w_run_next;
            r_run_max <= w_max_next;
            if (!hold) begin
                r_hex0 <= w_seg0;
                r_hex1 <= w_seg1;
            end
        end
    end

    assign evt       = r_evt;
    assign count_bcd = r_count;
    assign ovf       = r_ovf;
    assign run_max   = r_run_max;
    assign hex0      = r_hex0;
    assign hex1      = r_hex1;

endmodule

// File: tb/tb_match_event_counter.sv
// Bench for match_event_counter: cycle model compared every cycle plus
// directed scenarios with hand-computed expectations.
module tb_match_event_counter;

    localparam int RUN_W = 4;
    localparam int RUN_LIM = 15;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             z = 1'b0;
    logic             clr = 1'b0;
    logic             hold = 1'b0;
    logic             evt;
    logic [7:0]       count_bcd;
    logic             ovf;
    logic [RUN_W-1:0] run_max;
    logic [6:0]       hex0;
    logic [6:0]       hex1;

    int n_pass = 0;
    int n_total = 0;

    match_event_counter #(.RUN_W(RUN_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .z         (z),
        .clr       (clr),
        .hold      (hold),
        .evt       (evt),
        .count_bcd (count_bcd),
        .ovf       (ovf),
        .run_max   (run_max),
        .hex0      (hex0),
        .hex1      (hex1)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] seg(input int d);
        logic [6:0] s;
        case (d)
            0: s = 7'h40;
            1: s = 7'h79;
            2: s = 7'h24;
            3: s = 7'h30;
            4: s = 7'h19;
            5: s = 7'h12;
            6: s = 7'h02;
            7: s = 7'h78;
            8: s = 7'h00;
            9: s = 7'h10;
            default: s = 7'h7f;
        endcase
        return s;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Behavioural model: integer event count, run lengths as integers
    int         m_cnt = 0;
    bit         m_ovf = 0;
    bit         m_evt = 0;
    bit         m_zq = 0;
    int         m_run = 0;
    int         m_max = 0;
    logic [6:0] m_hex0 = 7'h40;
    logic [6:0] m_hex1 = 7'h40;
    bit         m_valid = 0;
    int         evt_seen = 0;

    always @(posedge clk) begin
        bit ev;
        if (reset) begin
            m_cnt = 0; m_ovf = 0; m_evt = 0; m_zq = 0;
            m_run = 0; m_max = 0;
            m_hex0 = seg(0); m_hex1 = seg(0);
        end else begin
            ev = z && !m_zq;
            m_zq = z;
            if (clr) begin
                m_cnt = 0; m_ovf = 0; m_evt = 0; m_run = 0; m_max = 0;
            end else begin
                if (ev) begin
                    m_cnt = m_cnt + 1;
                    if (m_cnt == 100) begin
                        m_cnt = 0;
                        m_ovf = 1;
                    end
                end
                m_evt = ev;
                m_run = z ? ((m_run + 1 > RUN_LIM) ? RUN_LIM : m_run + 1) : 0;
                if (m_run > m_max) m_max = m_run;
            end
            if (!hold) begin
                m_hex0 = seg(m_cnt % 10);
                m_hex1 = seg(m_cnt / 10);
            end
        end
        m_valid = 1;
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("cyc_count", count_bcd, ((m_cnt / 10) << 4) | (m_cnt % 10));
            check("cyc_evt", evt, m_evt);
            check("cyc_ovf", ovf, m_ovf);
            check("cyc_run_max", run_max, m_max);
            check("cyc_hex0", hex0, m_hex0);
            check("cyc_hex1", hex1, m_hex1);
            if (evt) evt_seen++;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulses(input int n);
        repeat (n) begin
            z = 1'b1; tick();
            z = 1'b0; tick();
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; z = 1'b0; clr = 1'b0; hold = 1'b0;
        tick(2);
        reset = 1'b0;
    endtask

    initial begin
        // 1: reset state
        do_reset();
        check("rst_count", count_bcd, 8'h00);
        check("rst_ovf", ovf, 0);
        check("rst_run_max", run_max, 0);
        check("rst_hex0", hex0, 7'b1000000);
        check("rst_hex1", hex1, 7'b1000000);
        check("rst_evt", evt, 0);

        // 2: runs of 3 and 5
        @(negedge clk);
        evt_seen = 0;
        @(posedge clk); #1;
        z = 1'b1; tick(3);
        z = 1'b0; tick(2);
        z = 1'b1; tick(5);
        z = 1'b0; tick(2);
        @(negedge clk); #1;
        check("run_count", count_bcd, 8'h02);
        check("run_evt_pulses", evt_seen, 2);
        check("run_max5", run_max, 5);
        @(posedge clk); #1;

        // 3: wrap at 99
        do_reset();
        pulses(99);
        check("wrap_99", count_bcd, 8'h99);
        check("wrap_no_ovf", ovf, 0);
        check("wrap_hex1_9", hex1, 7'b0010000);
        pulses(1);
        check("wrap_00", count_bcd, 8'h00);
        check("wrap_ovf", ovf, 1);
        check("wrap_hex0_0", hex0, 7'b1000000);

        // 4: clr coincident with an edge
        do_reset();
        pulses(7);
        check("clr_pre", count_bcd, 8'h07);
        z = 1'b1; clr = 1'b1; tick();
        clr = 1'b0;
        check("clr_count", count_bcd, 8'h00);
        check("clr_evt", evt, 0);
        check("clr_ovf", ovf, 0);
        check("clr_run_max", run_max, 0);
        tick();
        check("clr_no_spurious", count_bcd, 8'h00);
        z = 1'b0; tick();
        z = 1'b1; tick();
        check("clr_next_edge", count_bcd, 8'h01);
        z = 1'b0; tick();

        // 5: hold freezes the display
        do_reset();
        pulses(12);
        check("hold_pre", count_bcd, 8'h12);
        hold = 1'b1;
        pulses(3);
        check("hold_count", count_bcd, 8'h15);
        check("hold_hex1", hex1, 7'b1111001);
        check("hold_hex0", hex0, 7'b0100100);
        hold = 1'b0; tick();
        check("rel_hex1", hex1, 7'b1111001);
        check("rel_hex0", hex0, 7'b0010010);

        // 6: saturation, then reset mid-run
        do_reset();
        z = 1'b1; tick(20);
        check("sat_run_max", run_max, 15);
        check("sat_count", count_bcd, 8'h01);
        reset = 1'b1; clr = 1'b1; hold = 1'b1; tick();
        check("mid_rst_count", count_bcd, 8'h00);
        check("mid_rst_run_max", run_max, 0);
        check("mid_rst_evt", evt, 0);
        check("mid_rst_ovf", ovf, 0);
        check("mid_rst_hex0", hex0, 7'b1000000);
        check("mid_rst_hex1", hex1, 7'b1000000);
        reset = 1'b0; clr = 1'b0; hold = 1'b0; z = 1'b0;
        tick(3);

        @(negedge clk); #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
